// File: rtl/io_deser_pkg.sv
// Shared definitions for the IO-side serial/parallel converters.
//   state_t    : framing FSM states (IDLE, DATA, STOP)
//   START_LVL  : line level of a start bit
//   STOP_LVL   : line level of a stop bit
//   cnt_width  : bit-counter width for a given word width
package io_deser_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    STOP
  } state_t;

  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;

  // Counter must hold 0..WIDTH-1; never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/io_deser_obuf.sv
// Single-entry valid/ready holding register with overflow detect.
//   clk, rst  : clock, asynchronous active-high reset
//   wr, wdata : offer of a new word (one-cycle strobe)
//   dout      : held word, stable while dvalid=1
//   dvalid    : word available
//   dready    : consumer accepts the held word this cycle
//   ovf_evt   : new word dropped because the entry is full and not draining
module io_deser_obuf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] dout,
  output logic             dvalid,
  input  logic             dready,
  output logic             ovf_evt
);

  assign ovf_evt = wr && dvalid && !dready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout   <= '0;
      dvalid <= 1'b0;
    end else if (wr && (!dvalid || dready)) begin
      dout   <= wdata;
      dvalid <= 1'b1;
    end else if (dvalid && dready) begin
      dvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/io_in_deser.sv
// Framed serial-to-parallel deserializer fed by the IO input register cell.
//   IQC     : clock shared with the input cell
//   QRT     : asynchronous active-high reset
//   SIN     : serial bit (input cell IQZ), sampled when EN=1
//   EN      : bit strobe
//   DOUT    : received word, stable while DVALID=1
//   DVALID  : word available
//   DREADY  : consumer accepts the word
//   BUSY    : frame in progress
//   FERR    : sticky framing error (bad stop bit)
//   OVF     : sticky overflow (good word arrived while buffer full)
//   ERR_CLR : synchronous clear of FERR and OVF; a same-cycle set wins
module io_in_deser
  import io_deser_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             IQC,
  input  logic             QRT,
  input  logic             SIN,
  input  logic             EN,
  output logic [WIDTH-1:0] DOUT,
  output logic             DVALID,
  input  logic             DREADY,
  output logic             BUSY,
  output logic             FERR,
  output logic             OVF,
  input  logic             ERR_CLR
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg;
  logic             good;
  logic             ovf_evt;

  // good is registered; shreg stays untouched until the next frame's first
  // data strobe, at least two edges later, so it can feed the buffer directly.
  always_ff @(posedge IQC or posedge QRT) begin
    if (QRT) begin
      state <= IDLE;
      cnt   <= '0;
      shreg <= '0;
      good  <= 1'b0;
      FERR  <= 1'b0;
    end else begin
      good <= 1'b0;
      if (ERR_CLR) FERR <= 1'b0;
      if (EN) begin
        case (state)
          IDLE: begin
            if (SIN == START_LVL) begin
              state <= DATA;
              cnt   <= '0;
            end
          end
          DATA: begin
            shreg <= MSB_FIRST ? {shreg[WIDTH-2:0], SIN} : {SIN, shreg[WIDTH-1:1]};
            if (cnt == CW'(WIDTH - 1)) state <= STOP;
            else                       cnt   <= cnt + 1'b1;
          end
          STOP: begin
            state <= IDLE;
            if (SIN == STOP_LVL) good <= 1'b1;
            else                 FERR <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge IQC or posedge QRT) begin
    if (QRT)          OVF <= 1'b0;
    else if (ovf_evt) OVF <= 1'b1;
    else if (ERR_CLR) OVF <= 1'b0;
  end

  assign BUSY = (state != IDLE);

  io_deser_obuf #(.WIDTH(WIDTH)) u_obuf (
    .clk     (IQC),
    .rst     (QRT),
    .wr      (good),
    .wdata   (shreg),
    .dout    (DOUT),
    .dvalid  (DVALID),
    .dready  (DREADY),
    .ovf_evt (ovf_evt)
  );

endmodule

// File: tb/tb_io_in_deser.sv
module tb_io_in_deser;

  logic clk = 1'b0;
  logic rst, sin, en, dready, err_clr;
  logic [7:0] dout0, dout1;
  logic dvalid0, busy0, ferr0, ovf0;
  logic dvalid1, busy1, ferr1, ovf1;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_w;

  always #5 clk = ~clk;

  io_in_deser #(.WIDTH(8), .MSB_FIRST(1'b0)) dut0 (
    .IQC(clk), .QRT(rst), .SIN(sin), .EN(en), .DOUT(dout0), .DVALID(dvalid0),
    .DREADY(dready), .BUSY(busy0), .FERR(ferr0), .OVF(ovf0), .ERR_CLR(err_clr)
  );

  io_in_deser #(.WIDTH(8), .MSB_FIRST(1'b1)) dut1 (
    .IQC(clk), .QRT(rst), .SIN(sin), .EN(en), .DOUT(dout1), .DVALID(dvalid1),
    .DREADY(dready), .BUSY(busy1), .FERR(ferr1), .OVF(ovf1), .ERR_CLR(err_clr)
  );

  // First line bit lands in bit 7 instead of bit 0.
  function automatic logic [7:0] rev8(input logic [7:0] w);
    logic [7:0] r;
    for (int unsigned i = 0; i < 8; i++) r[7-i] = w[i];
    return r;
  endfunction

  // Scoreboard: every word handed over (DVALID & DREADY at the coming edge)
  // must be the oldest expected word, for both bit orders.
  always @(negedge clk) begin
    if (!rst && dvalid0 && dready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL sb_unexpected: got %h, required no word", dout0);
      end else begin
        exp_w = exp_q.pop_front();
        if (dout0 !== exp_w) begin errors++; $display("FAIL sb_lsb: got %h required %h", dout0, exp_w); end
        checks++;
        if (dout1 !== rev8(exp_w) || dvalid1 !== 1'b1) begin
          errors++; $display("FAIL sb_msb: got %h/%b required %h/1", dout1, dvalid1, rev8(exp_w));
        end
      end
    end
  end

  task automatic step;
    @(posedge clk); #1;
  endtask

  // Start bit, 8 data bits LSB first, stop bit; EN=0 gaps carry random SIN.
  task automatic send_frame(input logic [7:0] w, input logic stop_b, input int unsigned gap,
                            output logic busy_ok);
    logic [9:0] bits;
    bits = {stop_b, w, 1'b0};
    busy_ok = 1'b1;
    for (int unsigned k = 0; k < 10; k++) begin
      en = 1'b1; sin = bits[k]; step;
      if (k < 9) begin
        if (busy0 !== 1'b1 || busy1 !== 1'b1) busy_ok = 1'b0;
        for (int unsigned g = 0; g < gap; g++) begin
          en = 1'b0; sin = 1'($urandom_range(0, 1)); step;
          if (busy0 !== 1'b1) busy_ok = 1'b0;
        end
      end
    end
    en = 1'b1; sin = 1'b1;
  endtask

  task automatic test_reset;
    #2;
    checks++; if (dout0 !== 8'h00 || dout1 !== 8'h00) begin errors++; $display("FAIL rst_dout: got %h/%h required 00", dout0, dout1); end
    checks++; if (dvalid0 !== 1'b0 || busy0 !== 1'b0) begin errors++; $display("FAIL rst_ctl: got dv=%b busy=%b required 0", dvalid0, busy0); end
    checks++; if (ferr0 !== 1'b0 || ovf0 !== 1'b0) begin errors++; $display("FAIL rst_flags: got ferr=%b ovf=%b required 0", ferr0, ovf0); end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_basic;
    logic ok;
    dready = 1'b1;
    exp_q.push_back(8'h4D);
    send_frame(8'h4D, 1'b1, 0, ok);
    checks++; if (dvalid0 !== 1'b0 || busy0 !== 1'b0) begin errors++; $display("FAIL basic_early: got dv=%b busy=%b required 0/0", dvalid0, busy0); end
    step;
    checks++; if (dvalid0 !== 1'b1) begin errors++; $display("FAIL basic_dvalid: got %b required 1", dvalid0); end
    checks++; if (dout0 !== 8'h4D) begin errors++; $display("FAIL basic_lsb: got %h required 4d", dout0); end
    checks++; if (dout1 !== 8'hB2) begin errors++; $display("FAIL basic_msb: got %h required b2", dout1); end
    step;
    checks++; if (dvalid0 !== 1'b0) begin errors++; $display("FAIL basic_pulse: got %b required 0", dvalid0); end
    checks++; if (ferr0 !== 1'b0 || ovf0 !== 1'b0) begin errors++; $display("FAIL basic_flags: got %b/%b required 0/0", ferr0, ovf0); end
  endtask

  task automatic test_gaps;
    logic ok;
    exp_q.push_back(8'h4D);
    send_frame(8'h4D, 1'b1, 3, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL gaps_busy: got %b required 1", ok); end
    step;
    checks++; if (dvalid0 !== 1'b1 || dout0 !== 8'h4D || dout1 !== 8'hB2) begin
      errors++; $display("FAIL gaps_word: got %b %h %h required 1 4d b2", dvalid0, dout0, dout1); end
    step;
  endtask

  task automatic test_framing;
    logic ok;
    send_frame(8'h5E, 1'b0, 0, ok);
    checks++; if (ferr0 !== 1'b1 || busy0 !== 1'b0) begin errors++; $display("FAIL ferr_set: got ferr=%b busy=%b required 1/0", ferr0, busy0); end
    step;
    checks++; if (dvalid0 !== 1'b0 || busy0 !== 1'b0) begin errors++; $display("FAIL ferr_discard: got dv=%b busy=%b required 0/0", dvalid0, busy0); end
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 1, ok);
    step;
    checks++; if (dvalid0 !== 1'b1 || dout0 !== 8'hA5) begin errors++; $display("FAIL ferr_next: got %b %h required 1 a5", dvalid0, dout0); end
    checks++; if (ferr0 !== 1'b1) begin errors++; $display("FAIL ferr_sticky: got %b required 1", ferr0); end
    err_clr = 1'b1; step; err_clr = 1'b0;
    checks++; if (ferr0 !== 1'b0) begin errors++; $display("FAIL ferr_clr: got %b required 0", ferr0); end
    err_clr = 1'b1;
    send_frame(8'hC3, 1'b0, 0, ok);
    err_clr = 1'b0;
    checks++; if (ferr0 !== 1'b1) begin errors++; $display("FAIL ferr_setwins: got %b required 1", ferr0); end
    err_clr = 1'b1; step; err_clr = 1'b0;
  endtask

  task automatic test_overflow;
    logic ok;
    dready = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, 0, ok);
    step;
    checks++; if (dvalid0 !== 1'b1 || dout0 !== 8'h11) begin errors++; $display("FAIL ovf_first: got %b %h required 1 11", dvalid0, dout0); end
    send_frame(8'h22, 1'b1, 0, ok);
    step;
    checks++; if (dout0 !== 8'h11 || dvalid0 !== 1'b1) begin errors++; $display("FAIL ovf_hold: got %b %h required 1 11", dvalid0, dout0); end
    checks++; if (ovf0 !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b required 1", ovf0); end
    dready = 1'b1; step;
    checks++; if (dvalid0 !== 1'b0) begin errors++; $display("FAIL ovf_drain: got %b required 0", dvalid0); end
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, 0, ok);
    step;
    checks++; if (dvalid0 !== 1'b1 || dout0 !== 8'h5A || ovf0 !== 1'b1) begin
      errors++; $display("FAIL ovf_after: got %b %h ovf=%b required 1 5a 1", dvalid0, dout0, ovf0); end
    err_clr = 1'b1; step; err_clr = 1'b0;
    checks++; if (ovf0 !== 1'b0) begin errors++; $display("FAIL ovf_clr: got %b required 0", ovf0); end
  endtask

  task automatic test_back_to_back;
    logic ok;
    dready = 1'b0;
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1, 0, ok);
    step;
    exp_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b1, 0, ok);
    dready = 1'b1;
    step;
    checks++; if (dvalid0 !== 1'b1 || dout0 !== 8'h7E) begin errors++; $display("FAIL b2b_replace: got %b %h required 1 7e", dvalid0, dout0); end
    checks++; if (ovf0 !== 1'b0) begin errors++; $display("FAIL b2b_ovf: got %b required 0", ovf0); end
    step;
    checks++; if (dvalid0 !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b required 0", dvalid0); end
  endtask

  task automatic test_random;
    logic ok;
    logic [7:0] w;
    dready = 1'b1;
    for (int unsigned n = 0; n < 24; n++) begin
      w = 8'($urandom);
      exp_q.push_back(w);
      send_frame(w, 1'b1, $urandom_range(0, 2), ok);
      step;
    end
    repeat (3) step;
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rand_drain: got %0d pending required 0", exp_q.size()); end
    checks++; if (ferr0 !== 1'b0 || ovf0 !== 1'b0) begin errors++; $display("FAIL rand_flags: got %b/%b required 0/0", ferr0, ovf0); end
  endtask

  task automatic test_reset_mid;
    logic ok;
    dready = 1'b0;
    exp_q.push_back(8'h96);
    send_frame(8'h96, 1'b1, 0, ok);
    step;
    send_frame(8'h00, 1'b0, 0, ok);
    en = 1'b1;
    sin = 1'b0; step;
    sin = 1'b1; step;
    sin = 1'b0; step;
    #2 rst = 1'b1;
    #1;
    checks++; if (dout0 !== 8'h00 || dout1 !== 8'h00 || dvalid0 !== 1'b0) begin
      errors++; $display("FAIL rstmid_data: got %h %h dv=%b required 00 00 0", dout0, dout1, dvalid0); end
    checks++; if (busy0 !== 1'b0 || ferr0 !== 1'b0 || ovf0 !== 1'b0) begin
      errors++; $display("FAIL rstmid_ctl: got busy=%b ferr=%b ovf=%b required 0", busy0, ferr0, ovf0); end
    exp_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    en = 1'b1; sin = 1'b1;
    repeat (6) step;
    checks++; if (busy0 !== 1'b0 || dvalid0 !== 1'b0) begin errors++; $display("FAIL rstmid_idle: got busy=%b dv=%b required 0/0", busy0, dvalid0); end
    dready = 1'b1;
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, 2, ok);
    step;
    checks++; if (dvalid0 !== 1'b1 || dout0 !== 8'h3C) begin errors++; $display("FAIL rstmid_fresh: got %b %h required 1 3c", dvalid0, dout0); end
    step;
  endtask

  initial begin
    rst = 1'b1; sin = 1'b1; en = 1'b0; dready = 1'b0; err_clr = 1'b0;
    test_reset;
    test_basic;
    test_gaps;
    test_framing;
    test_overflow;
    test_back_to_back;
    test_random;
    test_reset_mid;
    repeat (2) step;
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL final_drain: got %0d pending required 0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
